// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD timer datapath.
// Contents: BCD digit width, BCD maximum, MM:SS digit wrap values and
// bcd_sat(), which clamps a loaded nibble above 9 to 9.
package timer_pkg;
  localparam int          BCD_W        = 4;
  localparam logic [3:0]  BCD_MAX      = 4'd9;
  localparam logic [3:0]  SEC_ONES_MAX = 4'd9;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  MIN_MAX      = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with parallel load and a wrap value.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load, in  - parallel load strobe and value (saturated to 9 on load)
//   dec       - decrement this cycle (borrow already resolved by the top)
//   wrap      - value taken when decrementing from 0
//   digit     - registered digit value
//   is_zero   - digit == 0
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] in,
  input  logic             dec,
  input  logic [BCD_W-1:0] wrap,
  output logic [BCD_W-1:0] digit,
  output logic             is_zero
);
  always_ff @(posedge clk) begin
    if (rst)                digit <= '0;
    else if (load)          digit <= bcd_sat(in);
    else if (dec) begin
      // Values above wrap (e.g. a loaded 7 in seconds tens) just step down.
      if (digit == '0)      digit <= wrap;
      else                  digit <= digit - 4'd1;
    end
  end

  assign is_zero = (digit == '0);
endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD down-counter (default MM:SS) with borrow chain,
// stop-at-zero or full-wrap mode and a registered expiry pulse.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   enablen   - active-low count enable
//   load, in  - parallel load strobe and BCD value (nibble i -> digit i)
//   count     - registered BCD value
//   zero      - all digits zero (combinational)
//   rco_L     - active-low ripple carry: low when zero and enabled
//   expired   - one-cycle pulse after a decrement reaches all-zero
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int                      NDIGITS      = 4,
  parameter logic [4*NDIGITS-1:0]    DIGIT_MAX    = 16'h9959,
  parameter bit                      STOP_AT_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enablen,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   in,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   zero,
  output logic                   rco_L,
  output logic                   expired
);
  logic [NDIGITS-1:0] dz, dec, borrow;
  logic               cnt_en, hold_zero, upper_zero, one_left;

  assign cnt_en    = !enablen && !load;
  assign zero      = &dz;
  assign hold_zero = STOP_AT_ZERO && zero;
  assign rco_L     = !(zero && !enablen);

  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < NDIGITS; i++) begin : g_dig
      if (i > 0) begin : g_borrow
        assign borrow[i] = borrow[i-1] & dz[i-1];
      end
      assign dec[i] = cnt_en && !hold_zero && borrow[i];

      bcd_digit_down u_dig (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .in     (in[BCD_W*i +: BCD_W]),
        .dec    (dec[i]),
        .wrap   (DIGIT_MAX[BCD_W*i +: BCD_W]),
        .digit  (count[BCD_W*i +: BCD_W]),
        .is_zero(dz[i])
      );
    end

    if (NDIGITS > 1) begin : g_upper
      assign upper_zero = &dz[NDIGITS-1:1];
    end else begin : g_single
      assign upper_zero = 1'b1;
    end
  endgenerate

  // A decrement lands on all-zero only from ...0001: digit 0 steps 1->0
  // and no higher digit sees a borrow.
  assign one_left = (count[BCD_W-1:0] == 4'd1) && upper_zero;

  always_ff @(posedge clk) begin
    if (rst)       expired <= 1'b0;
    else if (load) expired <= 1'b0;
    else           expired <= cnt_en && one_left;
  end
endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench: two instances (stop-at-zero and wrap mode) share stimulus.
module tb_bcd_down_timer;
  logic        clk = 1'b0;
  logic        rst, enablen, load;
  logic [15:0] in;
  logic [15:0] count_a, count_b;
  logic        zero_a, zero_b, rco_a, rco_b, exp_a, exp_b;

  always #5 clk = ~clk;

  bcd_down_timer #(.NDIGITS(4), .DIGIT_MAX(16'h9959), .STOP_AT_ZERO(1'b1)) u_a (
    .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(in),
    .count(count_a), .zero(zero_a), .rco_L(rco_a), .expired(exp_a));

  bcd_down_timer #(.NDIGITS(4), .DIGIT_MAX(16'h9959), .STOP_AT_ZERO(1'b0)) u_b (
    .clk(clk), .rst(rst), .enablen(enablen), .load(load), .in(in),
    .count(count_b), .zero(zero_b), .rco_L(rco_b), .expired(exp_b));

  typedef struct {
    bit          chk;
    logic [15:0] cnt;
    logic        expd;
    logic        en_n;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e, input logic [15:0] c,
                         input logic z, input logic r, input logic x);
    logic ez, er;
    ez = (e.cnt == 16'h0000);
    er = !(ez && !e.en_n);
    cmp({tag, ".count"},   c, e.cnt);
    cmp({tag, ".expired"}, {15'd0, x}, {15'd0, e.expd});
    cmp({tag, ".zero"},    {15'd0, z}, {15'd0, ez});
    cmp({tag, ".rco_L"},   {15'd0, r}, {15'd0, er});
  endtask

  // Monitor: one expected entry per clock edge per instance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      if (e.chk) cmp_all("A", e, count_a, zero_a, rco_a, exp_a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      if (e.chk) cmp_all("B", e, count_b, zero_b, rco_b, exp_b);
    end
  end

  // Drive one cycle of inputs and queue the value expected after the edge.
  task automatic step(input logic r, input logic ld, input logic en_n, input logic [15:0] v,
                      input bit ca, input logic [15:0] xa, input logic ea,
                      input bit cb, input logic [15:0] xb, input logic eb);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; enablen = en_n; in = v;
    e.chk = ca; e.cnt = xa; e.expd = ea; e.en_n = en_n; qa.push_back(e);
    e.chk = cb; e.cnt = xb; e.expd = eb; e.en_n = en_n; qb.push_back(e);
  endtask

  function automatic logic [15:0] bcd2(input int s);
    return 16'((s / 10) * 16 + (s % 10));
  endfunction

  initial begin
    rst = 1'b1; load = 1'b1; enablen = 1'b0; in = 16'h1234;

    // Reset dominates load and enable.
    step(1, 1, 0, 16'h1234, 1, 16'h0000, 0, 1, 16'h0000, 0);
    step(1, 1, 0, 16'h1234, 1, 16'h0000, 0, 1, 16'h0000, 0);

    // 01:00 counts down to 00:00, then holds (A).
    step(0, 1, 1, 16'h0100, 1, 16'h0100, 0, 1, 16'h0100, 0);
    for (int s = 59; s >= 0; s--)
      step(0, 0, 0, 16'h0, 1, bcd2(s), (s == 0), 0, 16'h0, 0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 16'h0, 1, 16'h0000, 0, 0, 16'h0, 0);

    // Seconds tens loaded above its max still steps down without early wrap.
    step(0, 1, 0, 16'h0075, 1, 16'h0075, 0, 1, 16'h0075, 0);
    for (int s = 74; s >= 0; s--)
      step(0, 0, 0, 16'h0, 1, bcd2(s), (s == 0), 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1, 16'h0000, 0, 0, 16'h0, 0);

    // Wrap mode vs stop mode from 00:01.
    step(0, 1, 1, 16'h0001, 1, 16'h0001, 0, 1, 16'h0001, 0);
    step(0, 0, 0, 16'h0, 1, 16'h0000, 1, 1, 16'h0000, 1);
    step(0, 0, 0, 16'h0, 1, 16'h0000, 0, 1, 16'h9959, 0);
    step(0, 0, 0, 16'h0, 1, 16'h0000, 0, 1, 16'h9958, 0);

    // Load of zero while expired is high: clears, never pulses.
    step(0, 1, 1, 16'h0001, 1, 16'h0001, 0, 1, 16'h0001, 0);
    step(0, 0, 0, 16'h0, 1, 16'h0000, 1, 1, 16'h0000, 1);
    step(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000, 0);
    step(0, 1, 1, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000, 0);

    // Saturation on load, then hold while disabled.
    step(0, 1, 1, 16'hAB3F, 1, 16'h9939, 0, 1, 16'h9939, 0);
    for (int k = 0; k < 5; k++)
      step(0, 0, 1, 16'h0, 1, 16'h9939, 0, 1, 16'h9939, 0);

    // Load wins over count; reset wins over load.
    step(0, 1, 0, 16'h0010, 1, 16'h0010, 0, 1, 16'h0010, 0);
    step(1, 1, 0, 16'h0010, 1, 16'h0000, 0, 1, 16'h0000, 0);
    step(0, 0, 1, 16'h0, 1, 16'h0000, 0, 1, 16'h0000, 0);

    begin
      int guard = 0;
      while ((qa.size() > 0 || qb.size() > 0) && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      #2;
      cmp("queue_drain", 16'(qa.size() + qb.size()), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
